// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // All-zero word decodes as a MIPS nop.
    localparam int unsigned NOP_WORD = 0;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned byte_cnt_width(input int unsigned data_width);
        return (bytes_per_word(data_width) > 1) ? $clog2(bytes_per_word(data_width)) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Fetch handshake and byte-serial program-load port of the instruction memory.
interface instr_mem_loadable_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_instr;
    logic                  fetch_fault;

    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic [ADDR_WIDTH:0]   load_len;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_ready;
    logic                  load_done;
    logic                  busy;

    modport master (
        output fetch_req, fetch_addr, load_start, load_base, load_len, load_valid, load_byte,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_ready, load_done, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_base, load_len, load_valid, load_byte,
        output fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_ready, load_done, busy
    );
endinterface

// File: rtl/instr_mem_byte_assembler.sv
// Shifts program bytes big-endian into a word; flags the byte that completes it.
module instr_mem_byte_assembler
    import instr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      byte_valid,
    input  logic [7:0]                                byte_data,
    input  logic [byte_cnt_width(DATA_WIDTH)-1:0]     byte_cnt,
    output logic                                      word_valid,
    output logic [DATA_WIDTH-1:0]                     word
);
    localparam int BPW       = bytes_per_word(DATA_WIDTH);
    localparam int CNT_WIDTH = byte_cnt_width(DATA_WIDTH);

    // Earlier bytes of the word; the final byte is appended combinationally.
    logic [DATA_WIDTH-9:0] partial;

    assign word       = {partial, byte_data};
    assign word_valid = byte_valid && (byte_cnt == CNT_WIDTH'(BPW - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            partial <= '0;
        end else if (byte_valid) begin
            partial <= word[DATA_WIDTH-9:0];
        end
    end
endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: registered fetch port plus byte-serial program loader.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_mem_loadable_if.slave bus
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int CNT_WIDTH = byte_cnt_width(DATA_WIDTH);

    state_e                state, next_state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [CNT_WIDTH-1:0]  byte_cnt;
    logic                  fetch_ready, load_ready, load_done, busy;
    logic                  byte_take, word_valid, mem_we;
    logic [DATA_WIDTH-1:0] word;
    logic                  fetch_take, fault;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  fetch_valid, fetch_fault;
    logic [DATA_WIDTH-1:0] fetch_instr;

    // NOTE: the array has no reset branch; contents start as nops and survive rst_n.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: DATA_WIDTH'(NOP_WORD)};

    assign byte_take  = bus.load_valid && load_ready && (remaining != '0);
    assign fetch_take = bus.fetch_req && fetch_ready;
    assign fetch_idx  = bus.fetch_addr[ADDR_WIDTH+1:2];
    assign fault      = (bus.fetch_addr[1:0] != 2'b00) ||
                        ((bus.fetch_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign mem_we     = rst_n && word_valid;

    instr_mem_byte_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_take),
        .byte_data  (bus.load_byte),
        .byte_cnt   (byte_cnt),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:  if (bus.load_start) next_state = ST_LOAD;
            ST_LOAD: if ((remaining == '0) ||
                         (word_valid && remaining == (ADDR_WIDTH+1)'(1))) next_state = ST_DONE;
            ST_DONE: next_state = ST_RUN;
            default: next_state = ST_RUN;
        endcase
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
        load_done   = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_RUN: begin
                fetch_ready = 1'b1;
                busy        = 1'b0;
            end
            ST_LOAD: load_ready = 1'b1;
            ST_DONE: load_done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
            byte_cnt  <= '0;
        end else if (state == ST_RUN && bus.load_start) begin
            ptr       <= bus.load_base;
            remaining <= bus.load_len;
            byte_cnt  <= '0;
        end else if (byte_take) begin
            if (word_valid) begin
                ptr       <= ptr + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH+1)'(1);
                byte_cnt  <= '0;
            end else begin
                byte_cnt  <= byte_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= word;
    end

    // Faulting fetches return a nop rather than an aliased word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_fault <= 1'b0;
        end else begin
            fetch_valid <= fetch_take;
            if (fetch_take) begin
                fetch_fault <= fault;
                fetch_instr <= fault ? DATA_WIDTH'(NOP_WORD) : mem[fetch_idx];
            end
        end
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.fetch_valid = fetch_valid;
    assign bus.fetch_instr = fetch_instr;
    assign bus.fetch_fault = fetch_fault;
    assign bus.load_ready  = load_ready;
    assign bus.load_done   = load_done;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomized bench for instr_mem_loadable against a word-array reference model.
module tb_instr_mem_loadable;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loadable_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instr_mem_loadable #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the word array plus the load/run phase as the rules describe it.
    logic [31:0] model_mem [DEPTH];
    int          m_phase = 0;   // 0 run, 1 loading, 2 done pulse
    int          m_rem, m_bytes, m_ptr;
    logic [31:0] m_word;
    bit          exp_valid, exp_check;
    logic [31:0] exp_instr;
    bit          exp_fault;
    int          done_cnt = 0;

    always @(posedge clk) begin
        bit          s_rst, s_req, s_start, s_lv;
        logic [31:0] s_addr;
        logic [7:0]  s_byte;
        int          s_base, s_len;
        s_rst   = rst_n;
        s_req   = bus.fetch_req;
        s_addr  = bus.fetch_addr;
        s_start = bus.load_start;
        s_base  = int'(bus.load_base);
        s_len   = int'(bus.load_len);
        s_lv    = bus.load_valid;
        s_byte  = bus.load_byte;
        if (!s_rst) begin
            m_phase   = 0;
            exp_valid = 0;
            exp_check = 1;
            exp_instr = 0;
            exp_fault = 0;
        end else begin
            exp_valid = (m_phase == 0) && s_req;
            exp_check = exp_valid;
            if (exp_valid) begin
                exp_fault = (s_addr % 4 != 0) || (s_addr >= 32'(DEPTH * 4));
                exp_instr = exp_fault ? 32'd0 : model_mem[s_addr / 4];
            end
            case (m_phase)
                0: if (s_start) begin
                    m_phase = 1; m_ptr = s_base; m_rem = s_len; m_bytes = 0;
                end
                1: if (m_rem == 0) begin
                    m_phase = 2;
                end else if (s_lv) begin
                    m_word = {m_word[23:0], s_byte};
                    m_bytes++;
                    if (m_bytes == 4) begin
                        model_mem[m_ptr] = m_word;
                        m_ptr   = (m_ptr + 1) % DEPTH;
                        m_rem--;
                        m_bytes = 0;
                        if (m_rem == 0) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        check("fetch_valid", bus.fetch_valid, exp_valid);
        if (exp_check) begin
            check("fetch_instr", bus.fetch_instr, exp_instr);
            check("fetch_fault", bus.fetch_fault, exp_fault);
        end
        check("fetch_ready", bus.fetch_ready, m_phase == 0);
        check("load_ready", bus.load_ready, m_phase == 1);
        check("load_done", bus.load_done, m_phase == 2);
        check("busy", bus.busy, m_phase != 0);
        if (bus.load_done === 1'b1) done_cnt++;
    end

    task automatic fetch_once(input logic [31:0] a, output logic v, output logic [31:0] ins,
                              output logic f);
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        @(negedge clk);
        bus.fetch_req  = 1'b0;
        v   = bus.fetch_valid;
        ins = bus.fetch_instr;
        f   = bus.fetch_fault;
    endtask

    function automatic logic [31:0] rand_addr();
        int kind = $urandom_range(0, 9);
        if (kind < 7) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (kind == 7) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        return ($urandom | 32'h400) & ~32'h3;
    endfunction

    // Bytes go out MSB first; abort_after >= 0 pulses reset after that many bytes.
    task automatic load_prog(input int base, input int len, input logic [63:0] data,
                             input int abort_after);
        int nbytes, gaps;
        nbytes   = len * 4;
        done_cnt = 0;
        @(negedge clk);
        bus.load_start = 1'b1;
        bus.load_base  = AW'(base);
        bus.load_len   = (AW+1)'(len);
        @(negedge clk);
        bus.load_start = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            if (i == abort_after) break;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                bus.load_valid = 1'b0;
                bus.fetch_req  = 1'($urandom_range(0, 1));
                bus.fetch_addr = rand_addr();
                @(negedge clk);
            end
            bus.load_valid = 1'b1;
            bus.load_byte  = data[8*(nbytes-1-i) +: 8];
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        bus.fetch_req  = 1'b0;
        if (abort_after >= 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("abort_no_done", done_cnt, 0);
        end else begin
            for (int w = 0; w < 10 && done_cnt == 0; w++) @(negedge clk);
            @(negedge clk);
            check("load_done_pulses", done_cnt, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        v, f;
        logic [31:0] ins;
        int          n;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_len   = '0;
        bus.load_valid = 1'b0;
        bus.load_byte  = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fetch_once(32'h0, v, ins, f);
        check("reset_fetch_valid", v, 1);
        check("reset_fetch_instr", ins, 32'h0);
        check("reset_fetch_fault", f, 0);
        check("reset_busy", bus.busy, 0);

        load_prog(0, 2, 64'h20080005_01095020, -1);
        fetch_once(32'h0, v, ins, f);
        check("load0_word0", ins, 32'h20080005);
        fetch_once(32'h4, v, ins, f);
        check("load0_word1", ins, 32'h01095020);

        // Three back-to-back fetches, results one per cycle in order.
        @(negedge clk); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        @(negedge clk); bus.fetch_addr = 32'h4;
        check("b2b_0", {bus.fetch_valid, bus.fetch_instr}, {1'b1, 32'h20080005});
        @(negedge clk); bus.fetch_addr = 32'h8;
        check("b2b_1", {bus.fetch_valid, bus.fetch_instr}, {1'b1, 32'h01095020});
        @(negedge clk); bus.fetch_req = 1'b0;
        check("b2b_2", {bus.fetch_valid, bus.fetch_instr}, {1'b1, 32'h00000000});
        @(negedge clk);
        check("b2b_drop", bus.fetch_valid, 0);

        fetch_once(32'h6, v, ins, f);
        check("misaligned", {f, ins}, {1'b1, 32'h0});
        fetch_once(32'h400, v, ins, f);
        check("out_of_range", {f, ins}, {1'b1, 32'h0});

        load_prog(255, 2, 64'h08000010_03E00008, -1);
        check("model_wrap_255", model_mem[255], 32'h08000010);
        check("model_wrap_0", model_mem[0], 32'h03E00008);
        fetch_once(32'h3FC, v, ins, f);
        check("wrap_word255", ins, 32'h08000010);
        fetch_once(32'h0, v, ins, f);
        check("wrap_word0", ins, 32'h03E00008);

        // load_start with a concurrent fetch, zero-length load.
        done_cnt = 0;
        @(negedge clk);
        bus.load_start = 1'b1; bus.load_base = '0; bus.load_len = '0;
        bus.fetch_req  = 1'b1; bus.fetch_addr = 32'h4;
        @(negedge clk);
        bus.load_start = 1'b0; bus.fetch_req = 1'b0;
        check("start_fetch_result", {bus.fetch_valid, bus.fetch_instr}, {1'b1, 32'h01095020});
        check("start_ready_low", bus.fetch_ready, 0);
        @(negedge clk);
        check("len0_done", bus.load_done, 1);
        @(negedge clk);
        check("len0_done_once", {bus.load_done, bus.fetch_ready}, 2'b01);
        fetch_once(32'h4, v, ins, f);
        check("len0_unchanged", ins, 32'h01095020);

        load_prog(10, 2, 64'hAABBCCDD_EE112233, 6);
        check("abort_ready", bus.fetch_ready, 1);
        fetch_once(32'd40, v, ins, f);
        check("abort_word0", ins, 32'hAABBCCDD);
        fetch_once(32'd44, v, ins, f);
        check("abort_word1", ins, 32'h0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_prog($urandom_range(0, DEPTH - 1), $urandom_range(0, 2),
                          {$urandom, $urandom}, -1);
            end else begin
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    bus.fetch_req  = 1'b1;
                    bus.fetch_addr = rand_addr();
                end
                @(negedge clk);
                bus.fetch_req = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
